// File: rtl/rr_arb_pkg.sv
// Shared encodings for the round-robin mux arbiter: packet-lock state and
// output-stage occupancy.
package rr_arb_pkg;

  localparam logic [0:0] LK_UNLOCKED = 1'b0;
  localparam logic [0:0] LK_LOCKED   = 1'b1;

  localparam logic [0:0] OS_EMPTY = 1'b0;
  localparam logic [0:0] OS_FULL  = 1'b1;

endpackage

// File: rtl/onehot_mux.sv
// Generic AND-OR multiplexer driven by a one-hot select; a zero select
// yields zero data.
module onehot_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic [CHANNELS-1:0]       i_sel,
  input  logic [CHANNELS*WIDTH-1:0] i_data,
  output logic [WIDTH-1:0]          o_data
);

  // OR together every slice gated by its select bit
  always_comb begin
    o_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      o_data = o_data | (i_data[i*WIDTH +: WIDTH] & {WIDTH{i_sel[i]}});
    end
  end

endmodule

// File: rtl/rr_grant_gen.sv
// Round-robin grant: rotate requests so the pointer sits at bit 0, pick the
// lowest set bit, rotate back. A held lock overrides arbitration.
module rr_grant_gen #(
  parameter int CHANNELS = 4,
  parameter int CH_W     = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] i_req,
  input  logic [CH_W-1:0]     i_ptr,
  input  logic                i_lock,
  input  logic [CH_W-1:0]     i_lock_ch,
  output logic [CHANNELS-1:0] o_grant
);

  logic [CHANNELS-1:0] w_req_rot;
  logic [CHANNELS-1:0] w_gnt_rot;
  logic [CHANNELS-1:0] w_gnt_free;
  logic [CHANNELS-1:0] w_gnt_lock;
  logic [CHANNELS-1:0] w_one;

  assign w_one = {{(CHANNELS-1){1'b0}}, 1'b1};

  // x & -x isolates the lowest set bit, i.e. the first requester at/after ptr
  always_comb begin
    w_req_rot  = CHANNELS'({i_req, i_req} >> i_ptr);
    w_gnt_rot  = w_req_rot & (~w_req_rot + w_one);
    w_gnt_free = CHANNELS'(({w_gnt_rot, w_gnt_rot} << i_ptr) >> CHANNELS);
    w_gnt_lock = w_one << i_lock_ch;
    if (i_lock) begin
      o_grant = w_gnt_lock;
    end else begin
      o_grant = w_gnt_free;
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready output channel
// between CHANNELS requesters, with optional packet-level grant locking.
module rr_mux_arbiter
  import rr_arb_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 4,
  parameter int PACKET_MODE = 0,
  parameter int CH_W        = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS-1:0]       in_last,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [CHANNELS-1:0]       grant_one_hot,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [CH_W-1:0]           out_channel,
  output logic                      out_last
);

  localparam bit PKT_EN = (PACKET_MODE != 0);

  logic [0:0]          r_os_state;
  logic [0:0]          r_lock_state;
  logic [CH_W-1:0]     r_ptr;
  logic [CH_W-1:0]     r_lock_ch;
  logic [WIDTH-1:0]    r_out_data;
  logic [CH_W-1:0]     r_out_channel;
  logic                r_out_last;

  logic [CHANNELS-1:0] w_grant;
  logic [WIDTH-1:0]    w_sel_data;
  logic [CH_W-1:0]     w_gidx;
  logic [CH_W-1:0]     w_ptr_next;
  logic                w_space;
  logic                w_accept;
  logic                w_last;

  rr_grant_gen #(
    .CHANNELS (CHANNELS),
    .CH_W     (CH_W)
  ) u_grant (
    .i_req     (in_valid),
    .i_ptr     (r_ptr),
    .i_lock    (r_lock_state == LK_LOCKED),
    .i_lock_ch (r_lock_ch),
    .o_grant   (w_grant)
  );

  onehot_mux #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS)
  ) u_mux (
    .i_sel  (w_grant),
    .i_data (in_data),
    .o_data (w_sel_data)
  );

  // Grant index, accept qualification and next pointer value
  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_gidx = w_gidx | (w_grant[i] ? CH_W'(i) : '0);
    end
    w_space    = (r_os_state == OS_EMPTY) | out_ready;
    w_accept   = |(in_valid & w_grant) & w_space;
    w_last     = PKT_EN & (|(in_last & w_grant));
    w_ptr_next = (w_gidx == CH_W'(CHANNELS - 1)) ? '0 : (w_gidx + CH_W'(1));
  end

  // Output register: reload on accept, drain on out_ready, otherwise hold
  always_ff @(posedge clk) begin
    if (reset) begin
      r_os_state    <= OS_EMPTY;
      r_out_data    <= '0;
      r_out_channel <= '0;
      r_out_last    <= 1'b0;
    end else if (w_accept) begin
      r_os_state    <= OS_FULL;
      r_out_data    <= w_sel_data;
      r_out_channel <= w_gidx;
      r_out_last    <= w_last;
    end else if (out_ready) begin
      r_os_state    <= OS_EMPTY;
    end
  end

  // Rotating pointer advances past the winner at the end of each packet
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_accept && (!PKT_EN || w_last)) begin
      r_ptr <= w_ptr_next;
    end
  end

  // Packet lock: held from a non-last beat until the last beat transfers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lock_state <= LK_UNLOCKED;
      r_lock_ch    <= '0;
    end else if (PKT_EN && w_accept) begin
      case (r_lock_state)
        LK_UNLOCKED: begin
          if (!w_last) begin
            r_lock_state <= LK_LOCKED;
            r_lock_ch    <= w_gidx;
          end
        end
        LK_LOCKED: begin
          if (w_last) begin
            r_lock_state <= LK_UNLOCKED;
          end
        end
        default: r_lock_state <= LK_UNLOCKED;
      endcase
    end
  end

  assign grant_one_hot = w_grant;
  assign in_ready      = w_grant & {CHANNELS{w_space}};
  assign out_valid     = (r_os_state == OS_FULL);
  assign out_data      = r_out_data;
  assign out_channel   = r_out_channel;
  assign out_last      = r_out_last;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: one instance per PACKET_MODE driven by shared
// stimulus, checked against a behavioural model and a beat scoreboard.
module tb_rr_mux_arbiter;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] c;
    logic       l;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  in_valid;
  logic [3:0]  in_last;
  logic [31:0] in_data;
  logic        out_ready;

  logic [3:0]  d_in_ready [2];
  logic [3:0]  d_gnt [2];
  logic        d_ov [2];
  logic [7:0]  d_od [2];
  logic [1:0]  d_oc [2];
  logic        d_ol [2];

  int    n_err = 0;
  int    n_checks = 0;
  int    m_ptr [2];
  bit    m_lock [2];
  int    m_lch [2];
  bit    m_full [2];
  beat_t sb0 [$];
  beat_t sb1 [$];
  logic [7:0] log0 [$];
  logic [1:0] chlog1 [$];

  always #5 clk = ~clk;

  rr_mux_arbiter #(.WIDTH(8), .CHANNELS(4), .PACKET_MODE(0)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last),
    .in_data(in_data), .in_ready(d_in_ready[0]), .grant_one_hot(d_gnt[0]),
    .out_valid(d_ov[0]), .out_ready(out_ready), .out_data(d_od[0]),
    .out_channel(d_oc[0]), .out_last(d_ol[0])
  );

  rr_mux_arbiter #(.WIDTH(8), .CHANNELS(4), .PACKET_MODE(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last),
    .in_data(in_data), .in_ready(d_in_ready[1]), .grant_one_hot(d_gnt[1]),
    .out_valid(d_ov[1]), .out_ready(out_ready), .out_data(d_od[1]),
    .out_channel(d_oc[1]), .out_last(d_ol[1])
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] mdl_grant(input int m);
    if (m_lock[m]) return 4'b0001 << m_lch[m];
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (m_ptr[m] + k) % 4;
      if (in_valid[idx]) return 4'b0001 << idx;
    end
    return 4'b0000;
  endfunction

  task automatic set_data(input int ch, input logic [7:0] v);
    in_data[ch*8 +: 8] = v;
  endtask

  // Check both instances against the model, then advance one clock
  task automatic step();
    #1;
    if (reset) begin
      for (int m = 0; m < 2; m++) begin
        m_ptr[m] = 0; m_lock[m] = 1'b0; m_lch[m] = 0; m_full[m] = 1'b0;
      end
      sb0.delete();
      sb1.delete();
    end else begin
      for (int m = 0; m < 2; m++) begin
        logic [3:0] g;
        bit sp, acc, have, lst;
        int gi;
        beat_t b;
        g  = mdl_grant(m);
        sp = !m_full[m] || out_ready;
        chk_eq($sformatf("grant%0d", m), d_gnt[m], g);
        chk_eq($sformatf("in_ready%0d", m), d_in_ready[m], sp ? g : 4'b0000);
        chk_eq($sformatf("out_valid%0d", m), d_ov[m], m_full[m]);
        if (d_ov[m] && out_ready) begin
          have = (m == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
          chk_eq($sformatf("sb_nonempty%0d", m), have, 1);
          if (have) begin
            b = (m == 0) ? sb0.pop_front() : sb1.pop_front();
            chk_eq($sformatf("out_data%0d", m), d_od[m], b.d);
            chk_eq($sformatf("out_channel%0d", m), d_oc[m], b.c);
            chk_eq($sformatf("out_last%0d", m), d_ol[m], b.l);
          end
          if (m == 0) log0.push_back(d_od[0]);
          else chlog1.push_back(d_oc[1]);
        end
        gi = 0;
        for (int i = 0; i < 4; i++) if (g[i]) gi = i;
        acc = (g != 4'b0000) && in_valid[gi] && sp;
        if (acc) begin
          lst = (m == 1) && in_last[gi];
          b.d = in_data[gi*8 +: 8];
          b.c = gi[1:0];
          b.l = lst;
          if (m == 0) sb0.push_back(b);
          else sb1.push_back(b);
          m_full[m] = 1'b1;
          if (m == 0 || in_last[gi]) m_ptr[m] = (gi + 1) % 4;
          if (m == 1) begin
            if (!m_lock[m] && !in_last[gi]) begin
              m_lock[m] = 1'b1;
              m_lch[m]  = gi;
            end else if (m_lock[m] && in_last[gi]) begin
              m_lock[m] = 1'b0;
            end
          end
        end else if (out_ready) begin
          m_full[m] = 1'b0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; in_valid = 4'b0000; in_last = 4'b0000;
    in_data = 32'h0000_0000; out_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    for (int m = 0; m < 2; m++) begin
      chk_eq("rst_out_valid", d_ov[m], 1'b0);
      chk_eq("rst_out_data", d_od[m], 8'h00);
      chk_eq("rst_out_channel", d_oc[m], 2'd0);
      chk_eq("rst_out_last", d_ol[m], 1'b0);
    end

    // Round-robin with all channels requesting
    for (int i = 0; i < 4; i++) set_data(i, 8'h10 + 8'(i));
    in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1'b1;
    log0.delete();
    repeat (6) step();
    chk_eq("rr_count", log0.size() >= 5, 1);
    for (int k = 0; k < 5 && k < log0.size(); k++)
      chk_eq($sformatf("rr_seq%0d", k), log0[k], 8'h10 + 8'(k % 4));

    // Idle drain
    in_valid = 4'b0000;
    repeat (2) step();
    chk_eq("idle_grant", d_gnt[0], 4'b0000);
    chk_eq("idle_in_ready", d_in_ready[0], 4'b0000);
    chk_eq("idle_out_valid", d_ov[0], 1'b0);

    // Backpressure on a ch1 beat
    set_data(1, 8'hA5); in_valid = 4'b0010;
    step();
    set_data(1, 8'h5B); out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_eq("bp_valid", d_ov[0], 1'b1);
      chk_eq("bp_data", d_od[0], 8'hA5);
      chk_eq("bp_channel", d_oc[0], 2'd1);
      chk_eq("bp_in_ready", d_in_ready[0], 4'b0000);
    end
    out_ready = 1'b1;
    step();
    chk_eq("bp_next_data", d_od[0], 8'h5B);
    in_valid = 4'b0000;
    repeat (2) step();

    // Wrap: ch2 grant moves ptr to 3, lone ch0 request wins and ptr becomes 1
    in_valid = 4'b0100;
    step();
    in_valid = 4'b0001;
    #1 chk_eq("wrap_grant", d_gnt[0], 4'b0001);
    step();
    in_valid = 4'b1111;
    #1 chk_eq("wrap_ptr1", d_gnt[0], 4'b0010);
    step();
    in_valid = 4'b0000;
    repeat (2) step();

    // Packet lock on ch0 with a gap, ch3 waiting throughout
    reset = 1'b1; step(); reset = 1'b0;
    chlog1.delete();
    in_last = 4'b1000; set_data(0, 8'hA0); set_data(3, 8'h3C);
    in_valid = 4'b1001; step();
    in_valid = 4'b1000;
    #1 chk_eq("lock_gap_grant", d_gnt[1], 4'b0001);
    step();
    in_valid = 4'b1001; set_data(0, 8'hA1); step();
    in_last = 4'b1001; set_data(0, 8'hA2); step();
    in_valid = 4'b1000;
    #1 chk_eq("post_pkt_grant", d_gnt[1], 4'b1000);
    step();
    in_valid = 4'b0000;
    repeat (2) step();
    chk_eq("pkt_count", chlog1.size(), 4);
    for (int k = 0; k < 4 && k < chlog1.size(); k++)
      chk_eq($sformatf("pkt_owner%0d", k), chlog1[k], (k < 3) ? 2'd0 : 2'd3);

    // Reset while locked on ch2 with a held beat
    in_last = 4'b0000; set_data(2, 8'hC2); out_ready = 1'b0;
    in_valid = 4'b0100; step();
    chk_eq("pre_rst_valid", d_ov[1], 1'b1);
    reset = 1'b1; step(); reset = 1'b0;
    chk_eq("mid_rst_valid", d_ov[1], 1'b0);
    chk_eq("mid_rst_channel", d_oc[1], 2'd0);
    out_ready = 1'b1; in_valid = 4'b0101;
    #1 chk_eq("post_rst_grant", d_gnt[1], 4'b0001);
    step();
    in_valid = 4'b0000;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
